// File: rtl/sumu_3.sv
// Registered 2-bit arithmetic unit: sum, truncated product with overflow flag,
// and absolute difference of two unsigned operands, one cycle of latency.
module sumu_3 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic [2:0] sum,
   output logic [2:0] mult,
   output logic [2:0] abb,
   output logic       mult_ovf
);

   logic [2:0] w_sum;
   logic [3:0] w_prod;
   logic [1:0] w_diff;

   logic [2:0] r_sum;
   logic [2:0] r_mult;
   logic [2:0] r_abb;
   logic       r_mult_ovf;

   assign w_sum  = {1'b0, a} + {1'b0, b};
   assign w_prod = {2'b00, a} * {2'b00, b};
   // Subtract in the order that cannot wrap, so the result is already |a - b|.
   assign w_diff = (a >= b) ? (a - b) : (b - a);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sum      <= 3'd0;
         r_mult     <= 3'd0;
         r_abb      <= 3'd0;
         r_mult_ovf <= 1'b0;
      end else begin
         r_sum      <= w_sum;
         r_mult     <= w_prod[2:0];
         r_abb      <= {1'b0, w_diff};
         r_mult_ovf <= w_prod[3];
      end
   end

   assign sum      = r_sum;
   assign mult     = r_mult;
   assign abb      = r_abb;
   assign mult_ovf = r_mult_ovf;

endmodule

// File: tb/tb_sumu_3.sv
// Self-checking bench for sumu_3: directed, exhaustive and random operands
// compared against an integer reference model one cycle after sampling.
module tb_sumu_3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] a   = 2'd0;
   logic [1:0] b   = 2'd0;
   logic [2:0] sum;
   logic [2:0] mult;
   logic [2:0] abb;
   logic       mult_ovf;

   int n_vec = 0;
   int n_err = 0;
   int abb_tab [4][4];

   sumu_3 dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .sum      (sum),
      .mult     (mult),
      .abb      (abb),
      .mult_ovf (mult_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   task automatic chk_model(input string tag, input int ea, input int eb);
      int p;
      p = ea * eb;
      chk({tag, ".sum"},  int'(sum),      ea + eb);
      chk({tag, ".mult"}, int'(mult),     p % 8);
      chk({tag, ".ovf"},  int'(mult_ovf), (p > 7) ? 1 : 0);
      chk({tag, ".abb"},  int'(abb),      (ea > eb) ? ea - eb : eb - ea);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".sum"},  int'(sum),      0);
      chk({tag, ".mult"}, int'(mult),     0);
      chk({tag, ".ovf"},  int'(mult_ovf), 0);
      chk({tag, ".abb"},  int'(abb),      0);
   endtask

   // Drive operands away from the active edge, then check just after it.
   task automatic apply(input string tag, input int va, input int vb);
      @(negedge clk);
      a = 2'(va);
      b = 2'(vb);
      @(posedge clk);
      #1;
      chk_model(tag, va % 4, vb % 4);
   endtask

   initial begin
      int ra, rb;
      logic [3:0] wide_a, wide_b;

      // Reset before any clock edge
      #1 rst = 1'b1;
      a = 2'd3;
      b = 2'd2;
      #1 chk_zero("reset_pre_edge");
      @(posedge clk);
      #1 chk_zero("reset_held");
      @(negedge clk);
      a = 2'd0;
      b = 2'd0;
      rst = 1'b0;
      @(posedge clk);
      #1 chk_model("baseline", 0, 0);

      // Directed: 11 and 10 truncate to 3 and 2 on the 2-bit ports
      wide_a = 4'd11;
      wide_b = 4'd10;
      @(negedge clk);
      a = wide_a[1:0];
      b = wide_b[1:0];
      @(posedge clk);
      #1;
      chk("dir.sum",  int'(sum),      5);
      chk("dir.mult", int'(mult),     6);
      chk("dir.abb",  int'(abb),      1);
      chk("dir.ovf",  int'(mult_ovf), 0);

      apply("ovf33", 3, 3);
      chk("ovf33.mult_abs", int'(mult), 1);
      chk("ovf33.flag_abs", int'(mult_ovf), 1);
      apply("p13", 1, 3);

      // Exhaustive back-to-back sweep
      for (int i = 0; i < 16; i++) begin
         apply($sformatf("sweep%0d", i), i / 4, i % 4);
         abb_tab[i / 4][i % 4] = int'(abb);
      end
      for (int x = 0; x < 4; x++)
         for (int y = x + 1; y < 4; y++)
            chk($sformatf("sym%0d%0d", x, y), abb_tab[x][y], abb_tab[y][x]);

      // Operand changes between edges must not reach the outputs
      apply("hold_base", 3, 2);
      @(negedge clk);
      a = 2'd1;
      b = 2'd0;
      #2 chk_model("hold_between", 3, 2);
      @(posedge clk);
      #1 chk_model("hold_next", 1, 0);

      // Async reset mid-stream, then release captures current operands
      apply("pre_rst", 3, 3);
      #2 rst = 1'b1;
      #1 chk_zero("mid_rst");
      a = 2'd2;
      b = 2'd1;
      @(posedge clk);
      #1 chk_zero("mid_rst_edge");
      @(negedge clk);
      rst = 1'b0;
      #1 chk_zero("post_release_no_edge");
      @(posedge clk);
      #1 chk_model("post_release", 2, 1);

      // Random stream
      for (int k = 0; k < 60; k++) begin
         ra = int'($urandom_range(0, 3));
         rb = int'($urandom_range(0, 3));
         apply($sformatf("rand%0d", k), ra, rb);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
